// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, instruction field positions
// and the {pc, instr} entry carried between fetch and decode.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory channel: in-order requests with grant,
// responses returned in issue order.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req, addr,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push and pop
// may share a cycle at any occupancy.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [AW:0]  count
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          empty;
   logic          full;
   logic          do_pop;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;
   assign head   = mem_q[rd_q];
   assign count  = cnt_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) rd_d = rd_q + AW'(1);
         cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues credit-limited
// requests, buffers responses and hands decode one word per cycle.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   fetch_stage_if.master    imem,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_pc,
   input  logic             dec_ready,
   output logic             dec_valid,
   output logic [XLEN-1:0]  dec_instr,
   output logic [XLEN-1:0]  dec_pc,
   output logic [6:0]       opcode,
   output logic [2:0]       f3,
   output logic [6:0]       f7,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            run_q, run_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   dat_cnt;
   logic [CW-1:0]   tag_cnt;
   logic [CW:0]     credit;
   logic            fire;
   logic            keep;
   logic            pop;
   logic            unused_tag;
   fetch_entry_t    tag_in, tag_head;
   fetch_entry_t    dat_in, dat_head;

   // Buffered plus in-flight words never exceed the buffer size.
   assign credit   = {1'b0, out_q} + {1'b0, dat_cnt};
   assign imem.req = run_q && !redirect
                     && (credit < (CW+1)'(FIFO_DEPTH));
   assign imem.addr = pc_q;

   assign fire = imem.req && imem.gnt;
   assign keep = imem.rvalid && !redirect && (drop_q == '0);
   assign pop  = dec_valid && dec_ready;

   assign tag_in = '{pc: pc_q, instr: '0};
   assign dat_in = '{pc: tag_head.pc, instr: imem.rdata};

   assign unused_tag = ^{tag_head.instr, tag_cnt};

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (fire),
      .push_data (tag_in),
      .pop       (imem.rvalid),
      .head      (tag_head),
      .count     (tag_cnt)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (keep),
      .push_data (dat_in),
      .pop       (pop),
      .head      (dat_head),
      .count     (dat_cnt)
   );

   always_comb begin
      run_d  = 1'b1;
      pc_d   = pc_q;
      out_d  = out_q + CW'(fire) - CW'(imem.rvalid);
      drop_d = drop_q;
      if (redirect) begin
         pc_d   = redirect_pc & ~XLEN'(3);
         // every response still in flight belongs to the old path
         drop_d = out_d;
      end else begin
         if (fire) pc_d = pc_q + XLEN'(4);
         if (imem.rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q  <= 1'b0;
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         run_q  <= run_d;
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   assign dec_valid = (dat_cnt != '0);
   assign dec_instr = dec_valid ? dat_head.instr : '0;
   assign dec_pc    = dec_valid ? dat_head.pc : '0;

   assign opcode = dec_instr[OPC_LSB +: 7];
   assign rd     = dec_instr[RD_LSB  +: 5];
   assign f3     = dec_instr[F3_LSB  +: 3];
   assign rs1    = dec_instr[RS1_LSB +: 5];
   assign rs2    = dec_instr[RS2_LSB +: 5];
   assign f7     = dec_instr[F7_LSB  +: 7];

   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      imem.rvalid |-> (out_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle-latency imem
// model; decode acceptances are logged and checked in order.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;

   fetch_stage_if imem ();

   fetch_stage #(
      .RESET_PC   (32'h0000_0100),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dec_ready   (dec_ready),
      .dec_valid   (dec_valid),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .opcode      (opcode),
      .f3          (f3),
      .f7          (f7),
      .rd          (rd),
      .rs1         (rs1),
      .rs2         (rs2)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   bit          rsp_en;
   logic [31:0] pend[$];
   logic [31:0] gnt_log[$];
   logic [31:0] acc_pc[$];
   logic [31:0] acc_ins[$];
   int          na;
   int          ng;

   function automatic logic [31:0] instr_of(logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: log grant/accept before the edge, update imem after it.
   task automatic step();
      bit          f;
      logic [31:0] a;
      #1;
      f = imem.req && imem.gnt;
      a = imem.addr;
      if (rst_n && !redirect && dec_valid && dec_ready) begin
         acc_pc.push_back(dec_pc);
         acc_ins.push_back(dec_instr);
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pend.delete();
         imem.rvalid = 1'b0;
         imem.rdata  = '0;
      end else begin
         if (imem.rvalid) void'(pend.pop_front());
         if (f) begin
            pend.push_back(a);
            gnt_log.push_back(a);
         end
         imem.rvalid = rsp_en && (pend.size() != 0);
         imem.rdata  = '0;
         if (imem.rvalid) imem.rdata = instr_of(pend[0]);
      end
   endtask

   task automatic wait_acc(int target);
      int k;
      k = 0;
      while (acc_pc.size() < target && k < 60) begin
         step();
         k++;
      end
      chk("acc_timeout", 32'(acc_pc.size() >= target), 32'd1);
   endtask

   task automatic chk_acc(int i, logic [31:0] exp);
      logic [31:0] p;
      logic [31:0] w;
      p = (i < acc_pc.size()) ? acc_pc[i] : 32'hDEAD_DEAD;
      w = (i < acc_ins.size()) ? acc_ins[i] : 32'hDEAD_DEAD;
      chk("acc_pc", p, exp);
      chk("acc_instr", w, instr_of(exp));
   endtask

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      dec_ready   = 1'b0;
      rsp_en      = 1'b1;
      imem.gnt    = 1'b1;
      imem.rvalid = 1'b0;
      imem.rdata  = '0;

      // reset state
      step();
      step();
      chk("rst_req", 32'(imem.req), 32'd0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_pc", dec_pc, 32'd0);
      chk("rst_instr", dec_instr, 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);

      // sequential fetch from RESET_PC
      rst_n     = 1'b1;
      dec_ready = 1'b1;
      step();
      chk("first_req", 32'(imem.req), 32'd1);
      chk("first_addr", imem.addr, 32'h100);
      wait_acc(4);
      for (int i = 0; i < 4; i++) begin
         chk_acc(i, 32'h100 + 32'(4 * i));
         chk("gnt_addr", gnt_log[i], 32'h100 + 32'(4 * i));
      end

      // decode stall
      dec_ready = 1'b0;
      step();
      chk("stall_valid0", 32'(dec_valid), 32'd1);
      chk("stall_pc0", dec_pc, 32'h110);
      repeat (4) step();
      chk("stall_req", 32'(imem.req), 32'd0);
      chk("stall_valid", 32'(dec_valid), 32'd1);
      chk("stall_pc", dec_pc, 32'h110);
      chk("stall_instr", dec_instr, 32'h1357_9ACF);
      chk("fld_opcode", 32'(opcode), 32'h4F);
      chk("fld_rd", 32'(rd), 32'h15);
      chk("fld_f3", 32'(f3), 32'h1);
      chk("fld_rs1", 32'(rs1), 32'h0F);
      chk("fld_rs2", 32'(rs2), 32'h15);
      chk("fld_f7", 32'(f7), 32'h09);
      chk("stall_grants", 32'(gnt_log.size()), 32'd6);
      dec_ready = 1'b1;
      wait_acc(8);
      for (int i = 4; i < 8; i++)
         chk_acc(i, 32'h110 + 32'(4 * (i - 4)));

      // redirect with two responses in flight
      rsp_en = 1'b0;
      repeat (6) step();
      chk("t3_req", 32'(imem.req), 32'd0);
      chk("t3_valid", 32'(dec_valid), 32'd0);
      na = acc_pc.size();
      ng = gnt_log.size();
      redirect    = 1'b1;
      redirect_pc = 32'h2000;
      #1;
      chk("redir_req", 32'(imem.req), 32'd0);
      step();
      redirect = 1'b0;
      rsp_en   = 1'b1;
      chk("redir_flush", 32'(dec_valid), 32'd0);
      wait_acc(na + 1);
      chk_acc(na, 32'h2000);
      chk("redir_gnt", gnt_log[ng], 32'h2000);

      // redirect while a response lands and the buffer holds a word
      dec_ready = 1'b0;
      repeat (8) step();
      chk("t4_req", 32'(imem.req), 32'd0);
      chk("t4_valid", 32'(dec_valid), 32'd1);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      step();
      chk("t4_rvalid", 32'(imem.rvalid), 32'd1);
      chk("t4_valid2", 32'(dec_valid), 32'd1);
      na = acc_pc.size();
      redirect    = 1'b1;
      redirect_pc = 32'h3000;
      step();
      redirect = 1'b0;
      chk("t4_flush", 32'(dec_valid), 32'd0);
      dec_ready = 1'b1;
      wait_acc(na + 1);
      chk_acc(na, 32'h3000);

      // back-to-back redirects, then PC wrap
      na = acc_pc.size();
      ng = gnt_log.size();
      redirect    = 1'b1;
      redirect_pc = 32'h5000;
      step();
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      wait_acc(na + 3);
      chk_acc(na, 32'hFFFF_FFFC);
      chk_acc(na + 1, 32'h0000_0000);
      chk_acc(na + 2, 32'h0000_0004);
      chk("wrap_gnt", gnt_log[ng], 32'hFFFF_FFFC);

      // misaligned target
      na = acc_pc.size();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0203;
      step();
      redirect = 1'b0;
      wait_acc(na + 1);
      chk_acc(na, 32'h200);

      // reset with a full buffer
      dec_ready = 1'b0;
      repeat (8) step();
      chk("t6_valid", 32'(dec_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(dec_valid), 32'd0);
      chk("t6_rst_pc", dec_pc, 32'd0);
      chk("t6_rst_instr", dec_instr, 32'd0);
      chk("t6_rst_req", 32'(imem.req), 32'd0);
      step();
      step();
      rst_n     = 1'b1;
      na        = acc_pc.size();
      dec_ready = 1'b1;
      wait_acc(na + 1);
      chk_acc(na, 32'h100);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
